// File: rtl/mtm_alu_deserializer_if.sv
// Bus bundle between the mtm_Alu serial line, the deserializer and the ALU core.
// The slave side is the deserializer. The master side is whatever drives the
// serial line and consumes the recovered operands.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] B;
  logic [31:0] A;
  logic [2:0]  op;
  logic [3:0]  crc;
  logic        r_valid;
  logic        err_data;

  modport master (
    output sin,
    input  B,
    input  A,
    input  op,
    input  crc,
    input  r_valid,
    input  err_data
  );

  modport slave (
    input  sin,
    output B,
    output A,
    output op,
    output crc,
    output r_valid,
    output err_data
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// mtm_Alu serial receiver.
// Samples one line bit per clock and rebuilds 11-bit frames:
//   start(0), type(0=DATA, 1=CTL), d7..d0, stop(1).
// A packet is eight DATA frames (B bytes 3..0, then A bytes 3..0, MSB byte
// first) closed by one CTL frame that carries op and crc. A clean packet
// produces a single-cycle r_valid. A framing or sequencing fault produces a
// single-cycle err_data and restarts packet assembly.
module mtm_alu_deserializer (
  input  logic                  clk,
  input  logic                  rst,
  mtm_alu_deserializer_if.slave bus
);

  localparam int         DATA_W     = 8;
  localparam int         WORD_W     = 32;
  localparam logic [3:0] PKT_FRAMES = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TYPE = 2'd1,
    BITS = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // control strobes decoded from the current state
  logic                type_ld;
  logic                bit_sh;
  logic                frm_eval;

  logic [2:0]          bit_cnt;
  logic [3:0]          frm_cnt;

  // frame capture stage
  logic [DATA_W-1:0]   shift_p0;
  logic                type_p0;

  // evaluated outputs, one cycle after the stop bit
  logic [WORD_W-1:0]   b_p1;
  logic [WORD_W-1:0]   a_p1;
  logic [2:0]          op_p1;
  logic [3:0]          crc_p1;
  logic                vld_p1;
  logic                err_p1;

  // Place a received byte into a 32-bit operand; lane 0 is the MSB byte.
  function automatic logic [WORD_W-1:0] put_byte(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] d
  );
    logic [WORD_W-1:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = d;
      2'd1:    r[23:16] = d;
      2'd2:    r[15:8]  = d;
      default: r[7:0]   = d;
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A low line in IDLE is the start bit, consumed at once,
  // so the following cycle already carries the type bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!bus.sin) state_nxt = TYPE;
      TYPE: state_nxt = BITS;
      BITS: if (bit_cnt == 3'd7) state_nxt = STOP;
      STOP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded control strobes.
  always_comb begin
    type_ld  = 1'b0;
    bit_sh   = 1'b0;
    frm_eval = 1'b0;
    case (state)
      TYPE:    type_ld  = 1'b1;
      BITS:    bit_sh   = 1'b1;
      STOP:    frm_eval = 1'b1;
      default: ;
    endcase
  end

  // Frame capture: type bit, data bit counter and MSB-first shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_p0  <= 1'b0;
      bit_cnt  <= 3'd0;
      shift_p0 <= '0;
    end else begin
      if (type_ld) begin
        type_p0 <= bus.sin;
        bit_cnt <= 3'd0;
      end
      if (bit_sh) begin
        shift_p0 <= {shift_p0[DATA_W-2:0], bus.sin};
        bit_cnt  <= bit_cnt + 3'd1;
      end
    end
  end

  // Frame evaluation in the stop cycle. The frame counter never exceeds 8,
  // because every evaluation that sees 8 clears it. Any fault drops the
  // partial packet and restarts assembly from byte 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_cnt <= 4'd0;
      b_p1    <= '0;
      a_p1    <= '0;
      op_p1   <= 3'd0;
      crc_p1  <= 4'd0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      if (frm_eval) begin
        if (!bus.sin) begin
          err_p1  <= 1'b1;
          frm_cnt <= 4'd0;
        end else if (!type_p0) begin
          if (frm_cnt == PKT_FRAMES) begin
            err_p1  <= 1'b1;
            frm_cnt <= 4'd0;
          end else begin
            if (frm_cnt[2]) begin
              a_p1 <= put_byte(a_p1, frm_cnt[1:0], shift_p0);
            end else begin
              b_p1 <= put_byte(b_p1, frm_cnt[1:0], shift_p0);
            end
            frm_cnt <= frm_cnt + 4'd1;
          end
        end else begin
          if (frm_cnt == PKT_FRAMES) begin
            op_p1  <= shift_p0[6:4];
            crc_p1 <= shift_p0[3:0];
            vld_p1 <= 1'b1;
          end else begin
            err_p1 <= 1'b1;
          end
          frm_cnt <= 4'd0;
        end
      end
    end
  end

  assign bus.B        = b_p1;
  assign bus.A        = a_p1;
  assign bus.op       = op_p1;
  assign bus.crc      = crc_p1;
  assign bus.r_valid  = vld_p1;
  assign bus.err_data = err_p1;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for the mtm_Alu serial deserializer.
// Inputs are driven on the falling clock edge and outputs are sampled there.
module tb_mtm_alu_deserializer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   vld_cnt;
  int   err_cnt;
  int   viol_cnt;
  logic prev_pulse;

  mtm_alu_deserializer_if bus ();

  mtm_alu_deserializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters and the exclusivity / no-back-to-back-pulse monitor
  always @(posedge clk) begin
    if (!rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (bus.r_valid) vld_cnt <= vld_cnt + 1;
      if (bus.err_data) err_cnt <= err_cnt + 1;
      if ((bus.r_valid && bus.err_data) || ((bus.r_valid || bus.err_data) && prev_pulse))
        viol_cnt <= viol_cnt + 1;
      prev_pulse <= bus.r_valid | bus.err_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sin = 1'b1;
    end
  endtask

  // Drive one frame; returns with the stop bit on the line.
  task automatic send_frame(input logic typ, input logic [7:0] d, input logic stopb,
                            input bit skip_start);
    logic [10:0] bits;
    bits = {1'b0, typ, d, stopb};
    for (int i = 10; i >= 0; i--) begin
      if (!(skip_start && i == 10)) begin
        @(negedge clk);
        bus.sin = bits[i];
      end
    end
  endtask

  // Full packet; gapped inserts 0..20 idle cycles between frames.
  task automatic send_packet(input logic [31:0] b, input logic [31:0] a,
                             input logic [7:0] ctl, input bit gapped, input bit skip_first_start);
    logic [63:0] w;
    w = {b, a};
    for (int i = 0; i < 8; i++) begin
      send_frame(1'b0, w[63-8*i -: 8], 1'b1, (i == 0) && skip_first_start);
      if (gapped) idle((i * 7) % 21);
    end
    send_frame(1'b1, ctl, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.sin = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.B !== 32'h0) begin n_fail++; $display("FAIL reset_B: got %h want %h", bus.B, 32'h0); end
    n_cmp++; if (bus.A !== 32'h0) begin n_fail++; $display("FAIL reset_A: got %h want %h", bus.A, 32'h0); end
    n_cmp++; if (bus.op !== 3'd0) begin n_fail++; $display("FAIL reset_op: got %b want 000", bus.op); end
    n_cmp++; if (bus.crc !== 4'd0) begin n_fail++; $display("FAIL reset_crc: got %h want 0", bus.crc); end
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b want 0", bus.r_valid); end
    n_cmp++; if (bus.err_data !== 1'b0) begin n_fail++; $display("FAIL reset_err_data: got %b want 0", bus.err_data); end
    rst = 1'b1;
    idle(3);
  endtask

  task automatic test_nominal();
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_packet(32'h01020304, 32'hA0B0C0D0, 8'h5A, 1'b0, 1'b0);
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_early_valid: got %b want 0", bus.r_valid); end
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL nominal_r_valid: got %b want 1", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'h01020304) begin n_fail++; $display("FAIL nominal_B: got %h want %h", bus.B, 32'h01020304); end
    n_cmp++; if (bus.A !== 32'hA0B0C0D0) begin n_fail++; $display("FAIL nominal_A: got %h want %h", bus.A, 32'hA0B0C0D0); end
    n_cmp++; if (bus.op !== 3'b101) begin n_fail++; $display("FAIL nominal_op: got %b want 101", bus.op); end
    n_cmp++; if (bus.crc !== 4'hA) begin n_fail++; $display("FAIL nominal_crc: got %h want a", bus.crc); end
    n_cmp++; if (bus.err_data !== 1'b0) begin n_fail++; $display("FAIL nominal_err: got %b want 0", bus.err_data); end
    @(negedge clk);
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_pulse_width: got %b want 0", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'h01020304) begin n_fail++; $display("FAIL nominal_B_hold: got %h want %h", bus.B, 32'h01020304); end
    idle(2);
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL nominal_vld_count: got %0d want 1", vld_cnt - v0); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL nominal_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_short_packet();
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(1'b0, 8'h11, 1'b1, 1'b0);
    send_frame(1'b0, 8'h22, 1'b1, 1'b0);
    send_frame(1'b0, 8'h33, 1'b1, 1'b0);
    send_frame(1'b1, 8'h10, 1'b1, 1'b0);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.err_data !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", bus.err_data); end
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL short_r_valid: got %b want 0", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'h11223304) begin n_fail++; $display("FAIL short_B_partial: got %h want %h", bus.B, 32'h11223304); end
    n_cmp++; if (bus.op !== 3'b101) begin n_fail++; $display("FAIL short_op_kept: got %b want 101", bus.op); end
    @(negedge clk);
    n_cmp++; if (bus.err_data !== 1'b0) begin n_fail++; $display("FAIL short_err_width: got %b want 0", bus.err_data); end
    send_packet(32'hDEADBEEF, 32'h12345678, 8'h3C, 1'b0, 1'b0);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL short_recover_valid: got %b want 1", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'hDEADBEEF) begin n_fail++; $display("FAIL short_recover_B: got %h want %h", bus.B, 32'hDEADBEEF); end
    n_cmp++; if (bus.A !== 32'h12345678) begin n_fail++; $display("FAIL short_recover_A: got %h want %h", bus.A, 32'h12345678); end
    n_cmp++; if (bus.op !== 3'b011) begin n_fail++; $display("FAIL short_recover_op: got %b want 011", bus.op); end
    n_cmp++; if (bus.crc !== 4'hC) begin n_fail++; $display("FAIL short_recover_crc: got %h want c", bus.crc); end
    idle(2);
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL short_vld_count: got %0d want 1", vld_cnt - v0); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL short_err_count: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_ninth_data();
    int v0, e0;
    logic [63:0] w;
    v0 = vld_cnt; e0 = err_cnt;
    w = {32'hCAFEBABE, 32'h0BADF00D};
    for (int i = 0; i < 8; i++) send_frame(1'b0, w[63-8*i -: 8], 1'b1, 1'b0);
    send_frame(1'b0, 8'h77, 1'b1, 1'b0);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.err_data !== 1'b1) begin n_fail++; $display("FAIL ninth_err: got %b want 1", bus.err_data); end
    n_cmp++; if (bus.A !== 32'h0BADF00D) begin n_fail++; $display("FAIL ninth_A_kept: got %h want %h", bus.A, 32'h0BADF00D); end
    n_cmp++; if (bus.B !== 32'hCAFEBABE) begin n_fail++; $display("FAIL ninth_B_kept: got %h want %h", bus.B, 32'hCAFEBABE); end
    send_frame(1'b1, 8'h70, 1'b1, 1'b0);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.err_data !== 1'b1) begin n_fail++; $display("FAIL ninth_ctl_err: got %b want 1", bus.err_data); end
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL ninth_ctl_valid: got %b want 0", bus.r_valid); end
    n_cmp++; if (bus.op !== 3'b011) begin n_fail++; $display("FAIL ninth_op_kept: got %b want 011", bus.op); end
    n_cmp++; if (bus.crc !== 4'hC) begin n_fail++; $display("FAIL ninth_crc_kept: got %h want c", bus.crc); end
    idle(2);
    n_cmp++; if (vld_cnt - v0 !== 0) begin n_fail++; $display("FAIL ninth_vld_count: got %0d want 0", vld_cnt - v0); end
    n_cmp++; if (err_cnt - e0 !== 2) begin n_fail++; $display("FAIL ninth_err_count: got %0d want 2", err_cnt - e0); end
  endtask

  task automatic test_framing();
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(1'b0, 8'h55, 1'b1, 1'b0);
    send_frame(1'b0, 8'h66, 1'b1, 1'b0);
    send_frame(1'b0, 8'h77, 1'b1, 1'b0);
    send_frame(1'b0, 8'h88, 1'b1, 1'b0);
    send_frame(1'b0, 8'h99, 1'b0, 1'b0);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.err_data !== 1'b1) begin n_fail++; $display("FAIL framing_err: got %b want 1", bus.err_data); end
    n_cmp++; if (bus.A !== 32'h0BADF00D) begin n_fail++; $display("FAIL framing_A_kept: got %h want %h", bus.A, 32'h0BADF00D); end
    n_cmp++; if (bus.B !== 32'h55667788) begin n_fail++; $display("FAIL framing_B_partial: got %h want %h", bus.B, 32'h55667788); end
    idle(2);
    send_packet(32'h00000001, 32'h80000000, 8'hF7, 1'b0, 1'b0);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL framing_recover_valid: got %b want 1", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'h00000001) begin n_fail++; $display("FAIL framing_recover_B: got %h want %h", bus.B, 32'h00000001); end
    n_cmp++; if (bus.A !== 32'h80000000) begin n_fail++; $display("FAIL framing_recover_A: got %h want %h", bus.A, 32'h80000000); end
    n_cmp++; if (bus.op !== 3'b111) begin n_fail++; $display("FAIL framing_recover_op: got %b want 111", bus.op); end
    n_cmp++; if (bus.crc !== 4'h7) begin n_fail++; $display("FAIL framing_recover_crc: got %h want 7", bus.crc); end
    idle(2);
    n_cmp++; if (err_cnt - e0 !== 1 || vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL framing_counts: got err %0d vld %0d want err 1 vld 1", err_cnt - e0, vld_cnt - v0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] w;
    logic [10:0] bits;
    w = {32'h13579BDF, 32'h2468ACE0};
    for (int i = 0; i < 6; i++) send_frame(1'b0, w[63-8*i -: 8], 1'b1, 1'b0);
    n_cmp++; if (bus.B !== 32'h13579BDF) begin n_fail++; $display("FAIL rstmid_B_before: got %h want %h", bus.B, 32'h13579BDF); end
    bits = {1'b0, 1'b0, 8'hAC, 1'b1};
    for (int i = 10; i >= 4; i--) begin
      @(negedge clk);
      bus.sin = bits[i];
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.B !== 32'h0) begin n_fail++; $display("FAIL rstmid_B: got %h want %h", bus.B, 32'h0); end
    n_cmp++; if (bus.A !== 32'h0) begin n_fail++; $display("FAIL rstmid_A: got %h want %h", bus.A, 32'h0); end
    n_cmp++; if (bus.op !== 3'd0 || bus.crc !== 4'd0) begin n_fail++; $display("FAIL rstmid_opcrc: got %b/%h want 000/0", bus.op, bus.crc); end
    n_cmp++; if (bus.r_valid !== 1'b0 || bus.err_data !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got %b/%b want 0/0", bus.r_valid, bus.err_data); end
    @(negedge clk);
    rst = 1'b1;
    bus.sin = 1'b1;
    idle(3);
    send_packet(32'h00000000, 32'hFFFFFFFF, 8'h25, 1'b0, 1'b0);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b want 1", bus.r_valid); end
    n_cmp++; if (bus.A !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rstmid_after_A: got %h want %h", bus.A, 32'hFFFFFFFF); end
    n_cmp++; if (bus.B !== 32'h0) begin n_fail++; $display("FAIL rstmid_after_B: got %h want %h", bus.B, 32'h0); end
    n_cmp++; if (bus.op !== 3'b010 || bus.crc !== 4'h5) begin n_fail++; $display("FAIL rstmid_after_opcrc: got %b/%h want 010/5", bus.op, bus.crc); end
    idle(2);
  endtask

  task automatic test_idle_gaps();
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_packet(32'h89ABCDEF, 32'h76543210, 8'h6B, 1'b1, 1'b0);
    n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_early_valid: got %b want 0", bus.r_valid); end
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'h89ABCDEF) begin n_fail++; $display("FAIL gaps_B: got %h want %h", bus.B, 32'h89ABCDEF); end
    n_cmp++; if (bus.A !== 32'h76543210) begin n_fail++; $display("FAIL gaps_A: got %h want %h", bus.A, 32'h76543210); end
    n_cmp++; if (bus.op !== 3'b110 || bus.crc !== 4'hB) begin n_fail++; $display("FAIL gaps_opcrc: got %b/%h want 110/b", bus.op, bus.crc); end
    idle(2);
    n_cmp++; if (err_cnt - e0 !== 0 || vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL gaps_counts: got err %0d vld %0d want err 0 vld 1", err_cnt - e0, vld_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_packet(32'h0F1E2D3C, 32'h4B5A6978, 8'h41, 1'b0, 1'b0);
    // start bit of the next packet goes out in the same cycle r_valid appears
    @(negedge clk); bus.sin = 1'b0;
    n_cmp++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'h0F1E2D3C || bus.A !== 32'h4B5A6978) begin n_fail++; $display("FAIL b2b_first_BA: got %h/%h want 0f1e2d3c/4b5a6978", bus.B, bus.A); end
    n_cmp++; if (bus.op !== 3'b100 || bus.crc !== 4'h1) begin n_fail++; $display("FAIL b2b_first_opcrc: got %b/%h want 100/1", bus.op, bus.crc); end
    send_packet(32'h11112222, 32'h33334444, 8'h1E, 1'b0, 1'b1);
    @(negedge clk); bus.sin = 1'b1;
    n_cmp++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b want 1", bus.r_valid); end
    n_cmp++; if (bus.B !== 32'h11112222 || bus.A !== 32'h33334444) begin n_fail++; $display("FAIL b2b_second_BA: got %h/%h want 11112222/33334444", bus.B, bus.A); end
    n_cmp++; if (bus.op !== 3'b001 || bus.crc !== 4'hE) begin n_fail++; $display("FAIL b2b_second_opcrc: got %b/%h want 001/e", bus.op, bus.crc); end
    idle(2);
    n_cmp++; if (err_cnt - e0 !== 0 || vld_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_counts: got err %0d vld %0d want err 0 vld 2", err_cnt - e0, vld_cnt - v0); end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    vld_cnt  = 0;
    err_cnt  = 0;
    viol_cnt = 0;
    rst      = 1'b0;
    bus.sin  = 1'b1;
    test_reset();
    test_nominal();
    test_short_packet();
    test_ninth_data();
    test_framing();
    test_reset_mid_frame();
    test_idle_gaps();
    test_back_to_back();
    n_cmp++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d violations want 0", viol_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
